swap_engine: RTL and testbench
==============================

Name: swap_engine

Overview:
Parametrised register-swap engine holding NREG registers of WIDTH bits. On a start request it exchanges any two registers, selected at runtime. The exchange runs in one of two modes: a three-step copy through a temporary register, or a three-step in-place XOR exchange. The block provides a load port, an asynchronous read port and a busy/done handshake, and serves as the general-purpose successor to the fixed three-register swap controller.

Parameters:
WIDTH, 6, data width of each register
NREG, 4, number of registers (minimum 2)
IDXW, $clog2(NREG), width of index ports (derived; do not override)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  swap request, sampled only in IDLE
idx_a  input  IDXW  first register index, captured with start
idx_b  input  IDXW  second register index, captured with start
mode  input  1  0 = temp-copy swap, 1 = XOR in-place swap; captured with start
wr_en  input  1  load strobe
wr_idx  input  IDXW  load target index
wr_data  input  WIDTH  load data
rd_idx  input  IDXW  read index
rd_data  output  WIDTH  combinational read, R[rd_idx]; 0 if rd_idx >= NREG
busy  output  1  high while a swap is in progress
done  output  1  one-cycle completion pulse
err  output  1  one-cycle pulse on rejected start

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; R[i]=(i+1) truncated to WIDTH; tmp=0; busy=0; done=0; err=0; captured idx/mode=0. Reset mid-swap aborts immediately and leaves only reset values, with no done pulse.
- States: IDLE, STEP1, STEP2, STEP3. Transitions:
  - IDLE->STEP1 on an accepted start.
  - STEP1->STEP2->STEP3->IDLE unconditionally.
- Start acceptance, in IDLE with start=1:
  - If idx_a>=NREG or idx_b>=NREG: reject. Pulse err=1 for the next cycle, stay in IDLE, no writes.
  - Otherwise: latch a=idx_a, b=idx_b, m=mode and go to STEP1.
- Writes, exactly one register write per step, at the edge leaving that step:
  - mode 0:
    - STEP1: tmp<=R[a]
    - STEP2: R[a]<=R[b]
    - STEP3: R[b]<=tmp
  - mode 1:
    - STEP1: R[a]<=R[a]^R[b]
    - STEP2: R[b]<=R[a]^R[b]
    - STEP3: R[a]<=R[a]^R[b]
- a==b (valid index): the FSM walks the same 3 steps and pulses done, but suppresses all R writes. This protects XOR mode from zeroing the register. tmp may still update.
- Timing: start is sampled at edge k. busy=1 in the cycles after edges k, k+1 and k+2, i.e. busy = (state != IDLE). After edge k+3, busy=0 and done=1 for exactly one cycle, with the swapped values visible on rd_data. Total latency is 3 cycles from start sample to results; done is registered.
- Back-to-back: start may be asserted in the same cycle that done=1, since the state is IDLE. The new swap then begins immediately.
- Load port:
  - wr_en in IDLE with wr_idx<NREG writes R[wr_idx]<=wr_data at the edge.
  - wr_en with wr_idx>=NREG is ignored silently.
  - wr_en while busy is ignored; the swap has exclusive write access.
  - wr_en and an accepted start in the same IDLE cycle: the load commits at that edge, and STEP1 uses the post-load value.
- start while busy is ignored, with no err and no queuing.
- Arithmetic: XOR is bitwise over WIDTH. No carries, no width growth.

Decomposition:
- Package swap_pkg:
  - state enum state_t {IDLE, STEP1, STEP2, STEP3} (2-bit encoding 00, 01, 10, 11)
  - mode constants MODE_TEMP=1'b0, MODE_XOR=1'b1
- Sub-module swap_regfile (params WIDTH, NREG):
  - NREG x WIDTH storage with one synchronous write port (we, widx, wdata).
  - Two asynchronous read ports: rd port plus an internal read of R[a]/R[b].
  - Synchronous reset to i+1.
- swap_engine holds the FSM, tmp, the write mux (load vs. step write), and the handshake.

Test Plan:
1. Reset, then read idx 0..3 -> rd_data = 1, 2, 3, 4; busy=0, done=0, err=0.
2. mode=0, start idx_a=0, idx_b=2 -> busy high for 3 cycles, then done pulse for 1 cycle; R0=3, R2=1, R1=2, R3=4 unchanged.
3. Load R1=6'h2A, R3=6'h15, then mode=1 swap(1,3) -> R1=6'h15, R3=6'h2A after 3 cycles; repeat with R1=R3=6'h3F -> values unchanged. Then swap(2,2) in mode 1 -> R2 unchanged, done still pulses at 3 cycles.
4. During busy, assert wr_en (idx 0, data 6'h3F) and start -> both ignored. Final values match the pure-swap result, and exactly one done pulse occurs.
5. Assert rst in STEP2 of a mode 0 swap(0,1) -> next cycle all R=i+1, busy=0, and no done pulse follows.
6. NREG=3 build: start with idx_b=3 -> err=1 for one cycle, busy stays 0, registers unchanged. Assert start in the done cycle of a valid swap -> second swap begins with busy=1 on the next cycle.

Source files
------------

// File: rtl/swap_pkg.sv
// Shared types and constants for the register-swap engine.
package swap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        STEP1 = 2'b01,
        STEP2 = 2'b10,
        STEP3 = 2'b11
    } state_t;

    localparam logic MODE_TEMP = 1'b0;
    localparam logic MODE_XOR  = 1'b1;

endpackage

// File: rtl/swap_regfile.sv
// NREG x WIDTH register file: one synchronous write port, three asynchronous reads.
// Reset loads each entry with its index plus one.
module swap_regfile #(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned NREG  = 4,
    parameter int unsigned IDXW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [IDXW-1:0]  widx,
    input  logic [WIDTH-1:0] wdata,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data,
    input  logic [IDXW-1:0]  a_idx,
    output logic [WIDTH-1:0] a_data,
    input  logic [IDXW-1:0]  b_idx,
    output logic [WIDTH-1:0] b_data
);

    logic [WIDTH-1:0] r_mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                r_mem[i] <= WIDTH'(i + 1);
            end
        end else if (we) begin
            r_mem[widx] <= wdata;
        end
    end

    // External read returns zero for indices past the last register.
    assign rd_data = (32'(rd_idx) < NREG) ? r_mem[rd_idx] : '0;
    assign a_data  = r_mem[a_idx];
    assign b_data  = r_mem[b_idx];

endmodule

// File: rtl/swap_engine.sv
// Swaps any two registers of a small register file, either through a temp
// register or by a three-step in-place XOR exchange, with a busy/done handshake.
module swap_engine
    import swap_pkg::*;
#(
    parameter int unsigned WIDTH = 6,
    parameter int unsigned NREG  = 4,
    parameter int unsigned IDXW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [IDXW-1:0]  idx_a,
    input  logic [IDXW-1:0]  idx_b,
    input  logic             mode,
    input  logic             wr_en,
    input  logic [IDXW-1:0]  wr_idx,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [IDXW-1:0]  rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             err
);

    state_t           r_state;
    state_t           w_next;
    logic [IDXW-1:0]  r_a;
    logic [IDXW-1:0]  r_b;
    logic             r_m;
    logic [WIDTH-1:0] r_tmp;
    logic             r_done;
    logic             r_err;

    logic [WIDTH-1:0] w_a_data;
    logic [WIDTH-1:0] w_b_data;
    logic             w_we;
    logic [IDXW-1:0]  w_widx;
    logic [WIDTH-1:0] w_wdata;
    logic             w_tmp_ld;
    logic             w_accept;
    logic             w_reject;
    logic             w_start_ok;
    logic             w_wr_ok;
    logic             w_same;

    swap_regfile #(
        .WIDTH (WIDTH),
        .NREG  (NREG),
        .IDXW  (IDXW)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we),
        .widx    (w_widx),
        .wdata   (w_wdata),
        .rd_idx  (rd_idx),
        .rd_data (rd_data),
        .a_idx   (r_a),
        .a_data  (w_a_data),
        .b_idx   (r_b),
        .b_data  (w_b_data)
    );

    assign w_start_ok = (32'(idx_a) < NREG) && (32'(idx_b) < NREG);
    assign w_wr_ok    = 32'(wr_idx) < NREG;
    // Self-swap keeps stepping but must never write, or XOR mode would clear it.
    assign w_same     = (r_a == r_b);

    always_comb begin
        w_next   = r_state;
        w_we     = 1'b0;
        w_widx   = r_a;
        w_wdata  = w_a_data ^ w_b_data;
        w_tmp_ld = 1'b0;
        w_accept = 1'b0;
        w_reject = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = w_start_ok;
                    w_reject = !w_start_ok;
                    if (w_start_ok) w_next = STEP1;
                end
                if (wr_en && w_wr_ok) begin
                    w_we    = 1'b1;
                    w_widx  = wr_idx;
                    w_wdata = wr_data;
                end
            end
            STEP1: begin
                w_next = STEP2;
                if (r_m == MODE_XOR) w_we = !w_same;
                else                 w_tmp_ld = 1'b1;
            end
            STEP2: begin
                w_next = STEP3;
                w_we   = !w_same;
                if (r_m == MODE_XOR) w_widx  = r_b;
                else                 w_wdata = w_b_data;
            end
            STEP3: begin
                w_next = IDLE;
                w_we   = !w_same;
                if (r_m != MODE_XOR) begin
                    w_widx  = r_b;
                    w_wdata = r_tmp;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_m     <= 1'b0;
            r_tmp   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= (r_state == STEP3);
            r_err   <= w_reject;
            if (w_accept) begin
                r_a <= idx_a;
                r_b <= idx_b;
                r_m <= mode;
            end
            if (w_tmp_ld) r_tmp <= w_a_data;
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign err  = r_err;

endmodule

// File: tb/tb_swap_engine.sv
// Directed self-checking bench for swap_engine: a 4-register and a 3-register
// instance share clock and reset.
module tb_swap_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start, mode, wr_en, busy, done, err;
    logic [1:0] idx_a, idx_b, wr_idx, rd_idx;
    logic [5:0] wr_data, rd_data;

    logic       t_start, t_mode, t_wr_en, t_busy, t_done, t_err;
    logic [1:0] t_idx_a, t_idx_b, t_wr_idx, t_rd_idx;
    logic [5:0] t_wr_data, t_rd_data;

    int n_checks = 0;
    int n_fails  = 0;

    swap_engine #(.WIDTH(6), .NREG(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start), .idx_a(idx_a), .idx_b(idx_b),
        .mode(mode), .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data),
        .rd_idx(rd_idx), .rd_data(rd_data), .busy(busy), .done(done), .err(err)
    );

    swap_engine #(.WIDTH(6), .NREG(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(t_start), .idx_a(t_idx_a), .idx_b(t_idx_b),
        .mode(t_mode), .wr_en(t_wr_en), .wr_idx(t_wr_idx), .wr_data(t_wr_data),
        .rd_idx(t_rd_idx), .rd_data(t_rd_data), .busy(t_busy), .done(t_done), .err(t_err)
    );

    task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd4(input logic [1:0] idx, input logic [7:0] exp, input string tag);
        rd_idx = idx;
        #1;
        check_eq(tag, 8'(rd_data), exp);
    endtask

    task automatic rd3(input logic [1:0] idx, input logic [7:0] exp, input string tag);
        t_rd_idx = idx;
        #1;
        check_eq(tag, 8'(t_rd_data), exp);
    endtask

    task automatic regs4(input logic [7:0] e0, e1, e2, e3, input string tag);
        rd4(2'd0, e0, {tag, "_r0"});
        rd4(2'd1, e1, {tag, "_r1"});
        rd4(2'd2, e2, {tag, "_r2"});
        rd4(2'd3, e3, {tag, "_r3"});
    endtask

    task automatic status4(input logic b, d, e, input string tag);
        check_eq({tag, "_busy"}, 8'(busy), 8'(b));
        check_eq({tag, "_done"}, 8'(done), 8'(d));
        check_eq({tag, "_err"},  8'(err),  8'(e));
    endtask

    task automatic load4(input logic [1:0] idx, input logic [5:0] data);
        wr_en = 1'b1; wr_idx = idx; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    // Full swap on the 4-register instance with handshake timing checks.
    task automatic swap4(input logic [1:0] a, b, input logic m,
                         input logic [7:0] e0, e1, e2, e3, input string tag);
        idx_a = a; idx_b = b; mode = m; start = 1'b1;
        tick();
        start = 1'b0; wr_en = 1'b0;
        status4(1'b1, 1'b0, 1'b0, {tag, "_c1"});
        tick();
        status4(1'b1, 1'b0, 1'b0, {tag, "_c2"});
        tick();
        status4(1'b1, 1'b0, 1'b0, {tag, "_c3"});
        tick();
        status4(1'b0, 1'b1, 1'b0, {tag, "_fin"});
        regs4(e0, e1, e2, e3, tag);
        tick();
        status4(1'b0, 1'b0, 1'b0, {tag, "_post"});
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; mode = 1'b0; wr_en = 1'b0;
        idx_a = '0; idx_b = '0; wr_idx = '0; rd_idx = '0; wr_data = '0;
        t_start = 1'b0; t_mode = 1'b0; t_wr_en = 1'b0;
        t_idx_a = '0; t_idx_b = '0; t_wr_idx = '0; t_rd_idx = '0; t_wr_data = '0;
        tick();
        tick();
        rst = 1'b0;

        // reset state
        status4(1'b0, 1'b0, 1'b0, "rst");
        regs4(8'h01, 8'h02, 8'h03, 8'h04, "rst");

        // temp-copy swap
        swap4(2'd0, 2'd2, 1'b0, 8'h03, 8'h02, 8'h01, 8'h04, "tmp02");

        // XOR swap, equal-value XOR swap, self-swap
        load4(2'd1, 6'h2A);
        load4(2'd3, 6'h15);
        swap4(2'd1, 2'd3, 1'b1, 8'h03, 8'h15, 8'h01, 8'h2A, "xor13");
        load4(2'd1, 6'h3F);
        load4(2'd3, 6'h3F);
        swap4(2'd1, 2'd3, 1'b1, 8'h03, 8'h3F, 8'h01, 8'h3F, "xoreq");
        swap4(2'd2, 2'd2, 1'b1, 8'h03, 8'h3F, 8'h01, 8'h3F, "self22");

        // load and start while busy are ignored
        load4(2'd1, 6'h11);
        idx_a = 2'd0; idx_b = 2'd1; mode = 1'b0; start = 1'b1;
        tick();
        idx_a = 2'd2; idx_b = 2'd3; mode = 1'b1;
        wr_en = 1'b1; wr_idx = 2'd0; wr_data = 6'h3F;
        tick();
        status4(1'b1, 1'b0, 1'b0, "busy_ign1");
        wr_idx = 2'd2;
        tick();
        start = 1'b0; wr_en = 1'b0;
        status4(1'b1, 1'b0, 1'b0, "busy_ign2");
        tick();
        status4(1'b0, 1'b1, 1'b0, "busy_fin");
        regs4(8'h11, 8'h03, 8'h01, 8'h3F, "busy");
        tick();
        status4(1'b0, 1'b0, 1'b0, "busy_post1");
        tick();
        status4(1'b0, 1'b0, 1'b0, "busy_post2");

        // load in the start cycle lands before STEP1 reads it
        wr_en = 1'b1; wr_idx = 2'd1; wr_data = 6'h05;
        swap4(2'd0, 2'd1, 1'b0, 8'h05, 8'h11, 8'h01, 8'h3F, "ldstart");

        // reset in STEP2 aborts the swap
        idx_a = 2'd0; idx_b = 2'd1; mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check_eq("abort_busy_pre", 8'(busy), 8'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        status4(1'b0, 1'b0, 1'b0, "abort");
        regs4(8'h01, 8'h02, 8'h03, 8'h04, "abort");
        tick();
        status4(1'b0, 1'b0, 1'b0, "abort_post");

        // NREG=3 instance: out-of-range start, load and read
        t_idx_a = 2'd0; t_idx_b = 2'd3; t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check_eq("n3_err", 8'(t_err), 8'd1);
        check_eq("n3_err_busy", 8'(t_busy), 8'd0);
        tick();
        check_eq("n3_err_off", 8'(t_err), 8'd0);
        check_eq("n3_err_busy2", 8'(t_busy), 8'd0);
        t_idx_a = 2'd3; t_idx_b = 2'd1; t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check_eq("n3_erra", 8'(t_err), 8'd1);
        t_wr_en = 1'b1; t_wr_idx = 2'd3; t_wr_data = 6'h3F;
        tick();
        t_wr_en = 1'b0;
        check_eq("n3_erra_off", 8'(t_err), 8'd0);
        rd3(2'd0, 8'h01, "n3_r0");
        rd3(2'd1, 8'h02, "n3_r1");
        rd3(2'd2, 8'h03, "n3_r2");
        rd3(2'd3, 8'h00, "n3_r3oob");

        // back-to-back: second start in the done cycle
        t_idx_a = 2'd0; t_idx_b = 2'd2; t_mode = 1'b0; t_start = 1'b1;
        tick();
        t_start = 1'b0;
        tick();
        tick();
        check_eq("b2b_busy1", 8'(t_busy), 8'd1);
        tick();
        check_eq("b2b_done1", 8'(t_done), 8'd1);
        check_eq("b2b_idle1", 8'(t_busy), 8'd0);
        rd3(2'd0, 8'h03, "b2b1_r0");
        rd3(2'd2, 8'h01, "b2b1_r2");
        t_idx_a = 2'd0; t_idx_b = 2'd1; t_mode = 1'b1; t_start = 1'b1;
        tick();
        t_start = 1'b0;
        check_eq("b2b_busy2", 8'(t_busy), 8'd1);
        check_eq("b2b_done_off", 8'(t_done), 8'd0);
        tick();
        tick();
        tick();
        check_eq("b2b_done2", 8'(t_done), 8'd1);
        rd3(2'd0, 8'h02, "b2b2_r0");
        rd3(2'd1, 8'h03, "b2b2_r1");
        rd3(2'd2, 8'h01, "b2b2_r2");
        tick();
        check_eq("b2b_done2_off", 8'(t_done), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
